// File: rtl/conv1d_pkg.sv
// Shared width helpers and saturation for the conv1d_stream slice.
// Optional build macro used by this slice: CONV1D_RELU_EN (clamp negative results to zero).
package conv1d_pkg;

   localparam int CONV1D_TAPS  = 5;
   localparam int CONV1D_IDX_W = $clog2(CONV1D_TAPS);

   function automatic int idx_w(input int taps);
      return (taps > 1) ? $clog2(taps) : 1;
   endfunction

   // Unsigned sample gains a sign bit before the signed multiply.
   function automatic int prod_w(input int data_w, input int coef_w);
      return data_w + 1 + coef_w;
   endfunction

   function automatic int acc_w(input int data_w, input int coef_w, input int taps);
      return prod_w(data_w, coef_w) + $clog2(taps);
   endfunction

   function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                     input int out_w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/conv1d_mac_tree.sv
// Product registers (S2) and adder tree with saturation (S3) for conv1d_stream.
// Build macro CONV1D_RELU_EN forces negative saturated results to zero.
module conv1d_mac_tree
   import conv1d_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter int COEF_W = 4,
   parameter int TAPS   = 5,
   parameter int OUT_W  = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         advance_i,
   input  logic                         s1_valid_i,
   input  logic [TAPS-1:0][DATA_W-1:0]  win_i,
   input  logic [TAPS-1:0][COEF_W-1:0]  coef_i,
   output logic                         out_valid_o,
   output logic [OUT_W-1:0]             out_data_o
);

   localparam int PROD_W = prod_w(DATA_W, COEF_W);
   localparam int ACC_W  = acc_w(DATA_W, COEF_W, TAPS);

   logic [TAPS-1:0][PROD_W-1:0] prod_d;
   logic [TAPS-1:0][PROD_W-1:0] prod_q;
   logic                        s2_valid_q;
   logic signed [ACC_W-1:0]     acc_d;
   logic [OUT_W-1:0]            res_d;
   logic                        out_valid_q;
   logic [OUT_W-1:0]            out_data_q;

   generate
      for (genvar gi = 0; gi < TAPS; gi++) begin : g_prod
         assign prod_d[gi] = PROD_W'($signed({1'b0, win_i[gi]})) * PROD_W'($signed(coef_i[gi]));
      end
   endgenerate

   always_comb begin
      acc_d = '0;
      for (int i = 0; i < TAPS; i++) begin
         acc_d = acc_d + ACC_W'($signed(prod_q[i]));
      end
   end

   always_comb begin
      res_d = OUT_W'(sat_signed(64'(acc_d), OUT_W));
`ifdef CONV1D_RELU_EN
      if (acc_d < 0) res_d = '0;
`endif
   end

   // out_data keeps the last result while no new one arrives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_q      <= '0;
         s2_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else if (advance_i) begin
         prod_q      <= prod_d;
         s2_valid_q  <= s1_valid_i;
         out_valid_q <= s2_valid_q;
         if (s2_valid_q) out_data_q <= res_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;

endmodule

// File: rtl/conv1d_stream.sv
// Streaming 1-D convolution: sliding window, coefficient bank and handshake.
// Build macro CONV1D_RELU_EN enables the ReLU clamp in the MAC tree.
module conv1d_stream
   import conv1d_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter int COEF_W = 4,
   parameter int TAPS   = CONV1D_TAPS,
   parameter int OUT_W  = 8,
   parameter int STRIDE = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_W-1:0]       in_data,
   input  logic                    in_sof,
   input  logic                    coef_we,
   input  logic [idx_w(TAPS)-1:0]  coef_idx,
   input  logic [COEF_W-1:0]       coef_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [OUT_W-1:0]        out_data
);

   localparam int IDX_W  = idx_w(TAPS);
   localparam int FILL_W = $clog2(TAPS + 1);
   localparam int STR_W  = (STRIDE > 1) ? $clog2(STRIDE) : 1;
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(TAPS);
   localparam logic [STR_W-1:0]  STR_LAST  = STR_W'(STRIDE - 1);

   logic                        advance;
   logic                        accept;
   logic [TAPS-1:0][DATA_W-1:0] win_d;
   logic [TAPS-1:0][DATA_W-1:0] win_q;
   logic [TAPS-1:0][COEF_W-1:0] coef_q;
   logic [FILL_W-1:0]           fill_d;
   logic [FILL_W-1:0]           fill_q;
   logic [STR_W-1:0]            stride_d;
   logic [STR_W-1:0]            stride_q;
   logic                        fire_d;
   logic                        fire_q;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;
   assign accept   = in_valid && advance;

   // Slot 0 is the oldest sample, slot TAPS-1 the newest.
   always_comb begin
      win_d    = win_q;
      fill_d   = fill_q;
      stride_d = stride_q;
      fire_d   = 1'b0;
      if (accept) begin
         if (in_sof) begin
            win_d           = '0;
            win_d[TAPS-1]   = in_data;
            fill_d          = FILL_W'(1);
            stride_d        = '0;
         end else begin
            for (int i = 0; i < TAPS - 1; i++) begin
               win_d[i] = win_q[i+1];
            end
            win_d[TAPS-1] = in_data;
            if (fill_q != FILL_FULL) fill_d = fill_q + FILL_W'(1);
            if (fill_d == FILL_FULL) begin
               fire_d   = (stride_q == '0);
               stride_d = (stride_q == STR_LAST) ? '0 : stride_q + STR_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_q    <= '0;
         fill_q   <= '0;
         stride_q <= '0;
         fire_q   <= 1'b0;
      end else if (advance) begin
         win_q    <= win_d;
         fill_q   <= fill_d;
         stride_q <= stride_d;
         fire_q   <= fire_d;
      end
   end

   // Writes land regardless of stalls; products on the same edge see the old value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         coef_q <= '0;
      end else begin
         for (int i = 0; i < TAPS; i++) begin
            if (coef_we && (coef_idx == IDX_W'(i))) coef_q[i] <= coef_data;
         end
      end
   end

   conv1d_mac_tree #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .TAPS   (TAPS),
      .OUT_W  (OUT_W)
   ) u_mac_tree (
      .clk         (clk),
      .rst_n       (rst_n),
      .advance_i   (advance),
      .s1_valid_i  (fire_q),
      .win_i       (win_q),
      .coef_i      (coef_q),
      .out_valid_o (out_valid),
      .out_data_o  (out_data)
   );

endmodule

// File: tb/tb_conv1d_stream.sv
// Self-checking bench for conv1d_stream: directed table, hand sequences, random vs model.
module tb_conv1d_stream;
   import conv1d_pkg::*;

   localparam int TAPS  = 5;
   localparam int NROWS = 10;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic                    in_valid = 1'b0, in_sof = 1'b0, coef_we = 1'b0, out_ready = 1'b1;
   logic [3:0]              in_data = '0, coef_data = '0;
   logic [CONV1D_IDX_W-1:0] coef_idx = '0;
   logic                    in_ready, out_valid;
   logic [7:0]              out_data;

   logic                    in_valid1 = 1'b0, in_sof1 = 1'b0, coef_we1 = 1'b0, out_ready1 = 1'b1;
   logic [3:0]              in_data1 = '0, coef_data1 = '0;
   logic [CONV1D_IDX_W-1:0] coef_idx1 = '0;
   logic                    in_ready1, out_valid1;
   logic [7:0]              out_data1;

   conv1d_stream u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_sof(in_sof), .coef_we(coef_we), .coef_idx(coef_idx), .coef_data(coef_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   conv1d_stream #(.STRIDE(2)) u_dut_s2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
      .in_sof(in_sof1), .coef_we(coef_we1), .coef_idx(coef_idx1), .coef_data(coef_data1),
      .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1)
   );

   int n_cmp = 0;
   int n_bad = 0;

   function automatic void check(string name, int got, int want);
      n_cmp++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endfunction

   function automatic int rl(int v);
`ifdef CONV1D_RELU_EN
      return (v < 0) ? 0 : v;
`else
      return v;
`endif
   endfunction

   function automatic int sat_ref(int v);
      if (v > 127) return rl(127);
      if (v < -128) return rl(-128);
      return rl(v);
   endfunction

   // Reference model: frame history plus current coefficients.
   typedef struct { int data; int cyc; } obs_t;
   obs_t got_q[$];
   int   got1_q[$];
   int   exp_q[$];
   int   hist[$];
   int   coef_m[TAPS];
   int   n_frame = 0;
   int   cyc = 0;
   int   last_acc_cyc = 0;
   obs_t mon_o;

   function automatic void model_accept(int d, bit sof);
      int s;
      if (sof) begin
         hist.delete();
         n_frame = 0;
      end
      hist.push_back(d);
      n_frame++;
      if (hist.size() > TAPS) void'(hist.pop_front());
      if (n_frame >= TAPS) begin
         s = 0;
         for (int i = 0; i < TAPS; i++) s += coef_m[i] * hist[i];
         exp_q.push_back(sat_ref(s));
      end
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst_n) begin
         hist.delete();
         n_frame = 0;
      end else begin
         check("in_ready_rule", int'(in_ready), int'(!out_valid || out_ready));
         if (in_valid && in_ready) begin
            model_accept(int'(in_data), in_sof);
            last_acc_cyc = cyc + 1;
         end
         if (out_valid && out_ready) begin
            mon_o.data = int'($signed(out_data));
            mon_o.cyc  = cyc;
            got_q.push_back(mon_o);
         end
         if (out_valid1 && out_ready1) got1_q.push_back(int'($signed(out_data1)));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(int d, bit sof);
      int k;
      in_valid = 1'b1;
      in_data  = 4'(d);
      in_sof   = sof;
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (k >= 50) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, want 1", k);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic write_coef(int idx, int val);
      coef_we   = 1'b1;
      coef_idx  = CONV1D_IDX_W'(idx);
      coef_data = 4'(val);
      tick();
      coef_we = 1'b0;
      if (idx < TAPS) coef_m[idx] = val;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      out_ready = 1'b1;
      repeat (6) tick();
   endtask

   task automatic check_single(string name, int expv);
      check({name, "_count"}, got_q.size(), 1);
      if (got_q.size() > 0) begin
         check({name, "_latency"}, got_q[0].cyc - last_acc_cyc, 2);
         check({name, "_value"}, got_q[0].data, expv);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic check_model(string name);
      check({name, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         check($sformatf("%s_%0d", name, i), got_q[i].data, exp_q[i]);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   typedef struct { int coef[TAPS]; int samp[TAPS]; int expv; } row_t;
   row_t rows[NROWS];
   int   want[$];
   int   held;
   int   stream[12];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, want $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rows[0].coef = '{1, 2, 3, 4, 5};     rows[0].samp = '{14, 7, 10, 9, 2};  rows[0].expv = 104;
      rows[1].coef = '{7, 7, 7, 7, 7};     rows[1].samp = '{15, 15, 15, 15, 15}; rows[1].expv = 127;
      rows[2].coef = '{-8, -8, -8, -8, -8}; rows[2].samp = '{15, 15, 15, 15, 15}; rows[2].expv = rl(-128);
      rows[3].coef = '{1, -1, 1, -1, 1};   rows[3].samp = '{3, 9, 0, 15, 6};   rows[3].expv = rl(-15);
      rows[4].coef = '{0, 0, 0, 0, -3};    rows[4].samp = '{1, 1, 1, 1, 5};    rows[4].expv = rl(-15);
      rows[5].coef = '{2, 0, -1, 0, 3};    rows[5].samp = '{8, 4, 12, 6, 1};   rows[5].expv = 7;
      rows[6].coef = '{-8, -8, -8, -8, -8}; rows[6].samp = '{0, 0, 0, 0, 1};   rows[6].expv = rl(-8);
      rows[7].coef = '{7, -8, 7, -8, 7};   rows[7].samp = '{15, 0, 15, 0, 15}; rows[7].expv = 127;
      rows[8].coef = '{1, 0, 0, 0, 0};     rows[8].samp = '{9, 1, 2, 3, 4};    rows[8].expv = 9;
      rows[9].coef = '{0, 0, 0, 0, 1};     rows[9].samp = '{9, 1, 2, 3, 4};    rows[9].expv = 4;
      for (int i = 0; i < TAPS; i++) coef_m[i] = 0;

      // Reset state
      repeat (3) begin
         @(negedge clk);
         check("reset_out_valid", int'(out_valid), 0);
         check("reset_out_data", int'(out_data), 0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_in_ready", int'(in_ready), 1);
      tick();

      // Directed table
      for (int r = 0; r < NROWS; r++) begin
         for (int t = 0; t < TAPS; t++) write_coef(t, rows[r].coef[t]);
         for (int t = 0; t < TAPS; t++) send(rows[r].samp[t], t == 0);
         drain();
         check_single($sformatf("row%0d", r), rows[r].expv);
         $display("row %0d: expected %0d", r, rows[r].expv);
      end

      // Back-to-back results with all-ones kernel
      for (int t = 0; t < TAPS; t++) write_coef(t, 1);
      send(14, 1'b1); send(7, 1'b0); send(10, 1'b0); send(9, 1'b0); send(2, 1'b0);
      send(4, 1'b0);  send(5, 1'b0); send(1, 1'b0);  send(8, 1'b0); send(6, 1'b0);
      drain();
      want = '{42, 32, 30, 21, 20, 24};
      check("seq_count", got_q.size(), want.size());
      for (int i = 0; i < got_q.size() && i < want.size(); i++) begin
         check($sformatf("seq_val%0d", i), got_q[i].data, want[i]);
         if (i > 0) check($sformatf("seq_gap%0d", i), got_q[i].cyc - got_q[i-1].cyc, 1);
      end
      got_q.delete();
      exp_q.delete();
      $display("seq: back-to-back window sums checked");

      // Backpressure: hold out_ready low for 4 cycles mid-stream
      for (int i = 0; i < 12; i++) stream[i] = (i * 5 + 3) % 16;
      for (int i = 0; i < 7; i++) send(stream[i], i == 0);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 4'(stream[7]);
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         if (j == 0) held = int'(out_data);
         check($sformatf("stall_in_ready%0d", j), int'(in_ready), 0);
         check($sformatf("stall_out_valid%0d", j), int'(out_valid), 1);
         check($sformatf("stall_out_data%0d", j), int'(out_data), held);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      for (int i = 7; i < 12; i++) send(stream[i], 1'b0);
      drain();
      check("stall_total", got_q.size(), 8);
      check_model("stall");
      $display("stall: 4-cycle backpressure checked");

      // Stride 2 instance
      for (int t = 0; t < TAPS; t++) begin
         coef_we1   = 1'b1;
         coef_idx1  = CONV1D_IDX_W'(t);
         coef_data1 = 4'd1;
         tick();
      end
      coef_we1 = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         in_valid1 = 1'b1;
         in_data1  = 4'(i);
         in_sof1   = (i == 1);
         tick();
      end
      in_valid1 = 1'b0;
      in_sof1   = 1'b0;
      repeat (6) tick();
      want = '{15, 25, 35};
      check("stride2_count", got1_q.size(), want.size());
      for (int i = 0; i < got1_q.size() && i < want.size(); i++) begin
         check($sformatf("stride2_val%0d", i), got1_q[i], want[i]);
      end
      got1_q.delete();
      $display("stride2: outputs checked");

      // Reset in the middle of a frame
      for (int t = 0; t < TAPS; t++) write_coef(t, t + 1);
      send(14, 1'b1); send(7, 1'b0); send(10, 1'b0);
      rst_n = 1'b0;
      for (int t = 0; t < TAPS; t++) coef_m[t] = 0;
      repeat (2) begin
         @(negedge clk);
         check("midreset_out_valid", int'(out_valid), 0);
         check("midreset_out_data", int'(out_data), 0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      got_q.delete();
      exp_q.delete();
      send(14, 1'b1); send(7, 1'b0); send(10, 1'b0); send(9, 1'b0); send(2, 1'b0);
      drain();
      check_single("after_reset", 0);
      for (int t = 0; t < TAPS; t++) write_coef(t, t + 1);
      send(14, 1'b1); send(7, 1'b0); send(10, 1'b0); send(9, 1'b0); send(2, 1'b0);
      drain();
      check_single("reloaded", 104);
      $display("reset: mid-frame reset and coefficient reload checked");

      // Random traffic against the model
      for (int b = 0; b < 5; b++) begin
         for (int t = 0; t < 8; t++) write_coef($urandom_range(0, 7), int'($urandom_range(0, 15)) - 8);
         for (int c = 0; c < 80; c++) begin
            in_valid  = ($urandom % 4) != 0;
            in_data   = 4'($urandom_range(0, 15));
            in_sof    = ($urandom % 12) == 0;
            out_ready = ($urandom % 4) != 0;
            tick();
         end
         drain();
         $display("random burst %0d: %0d results", b, got_q.size());
         check_model($sformatf("rand%0d", b));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
